acia_tx_arb: RTL

ACIA_TX_ARB -- requirements
Module: acia_tx_arb

---
 rtl/acia_pkg.sv | 13 +
 rtl/acia_rr2.sv | 15 +
 rtl/acia_tx_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/acia_pkg.sv
// Shared types and constants for the ACIA transmit arbiter.
package acia_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/acia_rr2.sv
// Combinational two-way round-robin picker: returns whether anyone is asking and which index wins.
module acia_rr2
    import acia_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    output logic               grant_any,
    output logic               pick
);

    assign grant_any = |valid;
    // On a tie the requester that did not go last gets the turn.
    assign pick = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/acia_tx_arb.sv
// Two-requester arbiter feeding a single serial transmitter, one byte per transmit cycle.
// Define ACIA_TX_ARB_LOCK_EN to let an owner holding its lock input keep the grant across bytes.
module acia_tx_arb
    import acia_pkg::*;
#(
    parameter int PRI = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req0_dat,
    input  logic [7:0] req1_dat,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic       req0_lock,
    input  logic       req1_lock,
    output logic [7:0] tx_dat,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       owner
);

    // Owner starts as the non-preferred side so PRI takes the first tie.
    localparam logic OWNER_RST = (PRI == 0) ? 1'b1 : 1'b0;

    arb_state_t         state;
    logic [NUM_REQ-1:0] valid_vec;
    logic [NUM_REQ-1:0] elig;
    logic               grant_any;
    logic               pick;
    logic               accept;

    assign valid_vec = {req1_valid, req0_valid};

`ifdef ACIA_TX_ARB_LOCK_EN
    logic locked;
    logic owner_lock;
    logic winner_lock;

    assign owner_lock  = owner ? req1_lock : req0_lock;
    assign winner_lock = pick ? req1_lock : req0_lock;

    always_comb begin
        elig = valid_vec;
        if (locked && owner_lock) begin
            elig = valid_vec & (owner ? 2'b10 : 2'b01);
        end
    end

    // Lock is only re-evaluated in IDLE, so a mid-transfer lock change waits for the next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                locked <= winner_lock;
            end else if (locked && !owner_lock) begin
                locked <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = req0_lock ^ req1_lock;
    assign elig        = valid_vec;
`endif

    acia_rr2 u_rr2 (
        .valid     (elig),
        .last      (owner),
        .grant_any (grant_any),
        .pick      (pick)
    );

    assign accept = (state == IDLE) && !tx_busy && grant_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_dat     <= 8'h00;
            tx_start   <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            owner      <= OWNER_RST;
        end else begin
            tx_start   <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ISSUE;
                        tx_dat     <= pick ? req1_dat : req0_dat;
                        owner      <= pick;
                        req0_ready <= ~pick;
                        req1_ready <= pick;
                        tx_start   <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                // Wait for the transmitter to acknowledge, then for it to finish the byte.
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
